// File: rtl/minmax_tracker_4bit.sv
// Streaming extremum tracker: takes a frame of FRAME_LEN unsigned 4-bit samples over
// valid/ready and reports max/min values with the index of their first occurrence.
module minmax_tracker_4bit #(
   parameter int FRAME_LEN = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_in_valid,
   input  logic [3:0] i_in_data,
   output logic       o_in_ready,
   output logic       o_busy,
   output logic       o_done,
   output logic [3:0] o_max_val,
   output logic [3:0] o_min_val,
   output logic [3:0] o_max_idx,
   output logic [3:0] o_min_idx,
   output logic [1:0] o_state
);

   // Handshake: a sample transfers on a rising edge where i_in_valid && o_in_ready;
   // o_in_ready is a registered flag that is high only in RUN.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

   state_t     r_state;
   logic [3:0] r_cnt;
   logic [3:0] r_max_val;
   logic [3:0] r_min_val;
   logic [3:0] r_max_idx;
   logic [3:0] r_min_idx;
   logic       r_in_ready;
   logic       r_busy;
   logic       r_done;

   logic [2:0] w_max_cmp;
   logic [2:0] w_min_cmp;
   logic       w_accept;

   // MSB-first magnitude compare; result is {eq, gt, sm} for a versus b.
   function automatic logic [2:0] cmp4(input logic [3:0] a, input logic [3:0] b);
      logic gt;
      logic sm;
      gt = 1'b0;
      sm = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (!gt && !sm) begin
            if (a[i] && !b[i]) begin
               gt = 1'b1;
            end else if (!a[i] && b[i]) begin
               sm = 1'b1;
            end
         end
      end
      return {(!gt && !sm), gt, sm};
   endfunction

   assign w_max_cmp = cmp4(i_in_data, r_max_val);
   assign w_min_cmp = cmp4(i_in_data, r_min_val);
   assign w_accept  = r_in_ready && i_in_valid;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_max_val  <= 4'd0;
         r_min_val  <= 4'd0;
         r_max_idx  <= 4'd0;
         r_min_idx  <= 4'd0;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state    <= S_RUN;
                  r_cnt      <= 4'd0;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt == 4'd0) begin
                     r_max_val <= i_in_data;
                     r_min_val <= i_in_data;
                     r_max_idx <= 4'd0;
                     r_min_idx <= 4'd0;
                  end else begin
                     // Strict gt/sm only: equal samples keep the earliest index.
                     if (w_max_cmp[1]) begin
                        r_max_val <= i_in_data;
                        r_max_idx <= r_cnt;
                     end
                     if (w_min_cmp[0]) begin
                        r_min_val <= i_in_data;
                        r_min_idx <= r_cnt;
                     end
                  end
                  if (r_cnt == LAST_IDX) begin
                     r_state    <= S_DONE;
                     r_in_ready <= 1'b0;
                     r_done     <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready = r_in_ready;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_max_val  = r_max_val;
   assign o_min_val  = r_min_val;
   assign o_max_idx  = r_max_idx;
   assign o_min_idx  = r_min_idx;
   assign o_state    = r_state;

endmodule

// File: doc/minmax_tracker_4bit.md
# minmax_tracker_4bit

Streaming extremum tracker that sits downstream of the 4-bit magnitude comparator. It accepts a frame of FRAME_LEN unsigned 4-bit samples over a valid/ready handshake. Each accepted sample is compared against the running maximum and minimum using Eq/Gt/Sm-style results. At the end of the frame it reports the max, the min and their sample indices, and pulses done.

## Interface
- FRAME_LEN, 8, samples per frame; legal range 2..16.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a frame; honoured only in IDLE.
- in_valid  input  1  in_data holds a sample.
- in_data  input  4  unsigned sample.
- in_ready  output  1  block accepts a sample this cycle; high only in RUN.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; results valid.
- max_val  output  4  largest sample of the last frame.
- min_val  output  4  smallest sample of the last frame.
- max_idx  output  4  index (0-based) of the first occurrence of max_val.
- min_idx  output  4  index (0-based) of the first occurrence of min_val.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE: in_ready=0, busy=0. start=1 moves to RUN and clears the sample counter. in_valid is ignored.
- RUN: in_ready=1. A sample is accepted when in_valid && in_ready at the clock edge.
  - Sample 0 loads max_val=min_val=in_data and max_idx=min_idx=0.
  - Each later sample k is compared against both registers.
    - Gt vs max_val updates max_val/max_idx=k.
    - Sm vs min_val updates min_val/min_idx=k.
    - Eq leaves both unchanged, so ties keep the earliest index.
  - The counter increments per accepted sample. Accepting sample FRAME_LEN-1 moves to DONE.
  - A cycle with in_valid=0 is a stall: no counter change and no update.
  - start in RUN is ignored.
- DONE: lasts exactly one cycle with done=1, in_ready=0 and busy=1, then goes to IDLE. start is ignored in DONE.
- Result registers hold their values from the end of one frame until sample 0 of the next frame overwrites them. They do not change at start.
- Comparison is unsigned over 4 bits. Indices are zero-extended to 4 bits.

## Timing
- Reset values: in_ready=0, busy=0, done=0, max_val=0, min_val=0, max_idx=0, min_idx=0. The state is IDLE and the counter is 0.
- in_ready and busy are decoded from registered state with no combinational path from inputs.
- start sampled in IDLE at edge t gives in_ready=1 from cycle t+1.
- A sample accepted at edge t is reflected in max_*/min_* from cycle t+1.
- The last sample is accepted at edge t. done=1 during cycle t+1, and in_ready is already 0 in that cycle. IDLE follows at t+2.
- With no stalls, start to done is FRAME_LEN+1 cycles. A back-to-back frame can start in the first IDLE cycle.
- rst mid-frame overrides everything in the same edge. The partial frame is discarded, no done pulse is produced, and outputs take their reset values.
- Simultaneous rst and start: rst wins.

## Test plan
- Reset: assert rst for 2 cycles with start=1 and in_valid=1 → all outputs 0 and no done; the block stays in IDLE after rst drops until a fresh start.
- Mixed frame: FRAME_LEN=8, samples 3,9,1,9,0,15,15,7 with no stalls → done exactly 9 cycles after start; max_val=15, max_idx=5; min_val=0, min_idx=4; the tie on 9 and 15 keeps the first index.
- All-equal frame: eight samples of 6 with random in_valid gaps → max_val=min_val=6 and max_idx=min_idx=0; done comes 1 cycle after the 8th accepted sample; stalled cycles change nothing.
- Extremes with a monotone frame: 15,14,...,8 → max 15 at idx 0, min 8 at idx 7. Then 0,1,...,7 back-to-back, starting in the first IDLE cycle → max 7 at idx 7, min 0 at idx 0.
- Protocol abuse: in_valid=1 in IDLE and DONE, and start pulses during RUN → no extra samples are counted and the frame length is unchanged. Results held between frames stay stable until sample 0 of the next frame.
- Reset mid-frame: rst after 4 of 8 samples → outputs 0 and no done. A following full frame of 2,5,5,1,8,8,0,3 → max 8 at idx 4, min 0 at idx 6.
